// File: rtl/ladybird_intc.sv
// rtl/ladybird_intc.sv - fixed-priority interrupt controller with claim/complete sequencing
// Latches source pulses into PENDING, masks with ENABLE, and serves one source at a time.
module ladybird_intc #(
    parameter int N_SRC  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              anrst,
    input  logic              nrst,
    input  logic              bus_req_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [3:0]        bus_wstrb_i,
    inout  wire  [31:0]       bus_data_io,
    output logic              bus_gnt_o,
    output logic              bus_data_gnt_o,
    input  logic [N_SRC-1:0]  src_int_i,
    output logic              irq_o,
    output logic [7:0]        irq_id_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] OFF_PENDING   = ADDR_W'('h0);
    localparam logic [ADDR_W-1:0] OFF_ENABLE    = ADDR_W'('h4);
    localparam logic [ADDR_W-1:0] OFF_CLAIM     = ADDR_W'('h8);
    localparam logic [ADDR_W-1:0] OFF_INSERVICE = ADDR_W'('hC);

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [7:0]        isid_q, isid_d;

    logic              rd_c, wr_c;
    logic              sel_pend_c, sel_en_c, sel_claim_c, sel_isvc_c;
    logic [31:0]       wdata_c;
    logic [31:0]       rdata_c;
    logic [N_SRC-1:0]  masked_c, cand_onehot_c, clr_c, w1c_c;
    logic              has_cand_c;
    logic [7:0]        cand_id_c, claim_id_c;
    logic              unused_wdata;

    assign rd_c        = bus_req_i & ~(|bus_wstrb_i);
    assign wr_c        = bus_req_i & (|bus_wstrb_i);
    assign sel_pend_c  = (bus_addr_i == OFF_PENDING);
    assign sel_en_c    = (bus_addr_i == OFF_ENABLE);
    assign sel_claim_c = (bus_addr_i == OFF_CLAIM);
    assign sel_isvc_c  = (bus_addr_i == OFF_INSERVICE);
    assign wdata_c     = bus_data_io;
    assign unused_wdata = ^wdata_c[31:8];

    assign bus_gnt_o      = 1'b1;
    assign bus_data_gnt_o = rd_c;
    assign bus_data_io    = rd_c ? rdata_c : 32'bz;

    // Descending scan so the lowest enabled pending index wins.
    always_comb begin
        masked_c      = pending_q & enable_q;
        has_cand_c    = |masked_c;
        cand_onehot_c = masked_c & (-masked_c);
        cand_id_c     = 8'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked_c[i]) begin
                cand_id_c = 8'(i + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        isid_d     = isid_q;
        clr_c      = '0;
        irq_o      = 1'b0;
        irq_id_o   = 8'd0;
        claim_id_c = 8'd0;
        case (state_q)
            ST_IDLE: begin
                irq_o      = has_cand_c;
                irq_id_o   = cand_id_c;
                claim_id_c = cand_id_c;
                if (rd_c && sel_claim_c && has_cand_c) begin
                    clr_c   = cand_onehot_c;
                    isid_d  = cand_id_c;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                irq_id_o   = isid_q;
                claim_id_c = isid_q;
                if (wr_c && sel_claim_c && (wdata_c[7:0] == isid_q)) begin
                    isid_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                isid_d  = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new pulse overrides both W1C and claim clearing in the same cycle.
    always_comb begin
        w1c_c     = (wr_c && sel_pend_c) ? wdata_c[N_SRC-1:0] : '0;
        pending_d = (pending_q & ~w1c_c & ~clr_c) | src_int_i;
        enable_d  = (wr_c && sel_en_c) ? wdata_c[N_SRC-1:0] : enable_q;
    end

    always_comb begin
        rdata_c = 32'd0;
        if (sel_pend_c) begin
            rdata_c = 32'(pending_q);
        end else if (sel_en_c) begin
            rdata_c = 32'(enable_q);
        end else if (sel_claim_c) begin
            rdata_c = {24'd0, claim_id_c};
        end else if (sel_isvc_c) begin
            rdata_c = {24'd0, isid_q};
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            enable_q  <= '0;
            isid_q    <= 8'd0;
        end else if (!nrst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            enable_q  <= '0;
            isid_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            isid_q    <= isid_d;
        end
    end

endmodule
